gnot16_arbiter: RTL and testbench

GNOT16_ARBITER -- requirements
Module: gnot16_arbiter

---
 rtl/gnot16_arbiter.sv | 155 +++++++++++++++
 tb/tb_gnot16_arbiter.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/gnot16_arbiter.sv
// Four-requester arbiter sharing a single 16-bit bitwise-NOT unit, with a registered result and valid/ready hold.
// Fixed lowest-index priority by default; define GNOT16_ARB_RR_EN for round-robin arbitration.

module gnot16 (
    input  logic [15:0] a_i,
    output logic [15:0] y_o
);
    assign y_o = ~a_i;
endmodule

// Handshake: a result is held in y/y_id while y_valid is high and is consumed on any
// rising edge where y_valid and y_ready are both high; a waiting request is issued on that same edge.
module gnot16_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic [63:0] a_bus,
    output logic [3:0]  gnt,
    output logic [15:0] y,
    output logic [1:0]  y_id,
    output logic        y_valid,
    input  logic        y_ready
);
    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

    state_t      state_q, state_d;
    logic        issue;
    logic [1:0]  win;
    logic [15:0] operand;
    logic [15:0] not_y;
    logic [3:0]  gnt_q, gnt_d;
    logic [15:0] y_q, y_d;
    logic [1:0]  y_id_q, y_id_d;
    logic        y_valid_q, y_valid_d;

`ifdef GNOT16_ARB_RR_EN
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] idx;
    logic       found;

    // Search starts at the pointer and wraps, so the last winner drops to lowest priority.
    always_comb begin
        win   = ptr_q;
        found = 1'b0;
        idx   = ptr_q;
        for (int k = 0; k < 4; k++) begin
            idx = ptr_q + k[1:0];
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (issue) begin
            ptr_d = win + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 2'd0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    always_comb begin
        win = 2'd0;
        if (req[0]) begin
            win = 2'd0;
        end else if (req[1]) begin
            win = 2'd1;
        end else if (req[2]) begin
            win = 2'd2;
        end else if (req[3]) begin
            win = 2'd3;
        end
    end
`endif

    assign operand = a_bus[16*win +: 16];

    gnot16 u_gnot16 (
        .a_i (operand),
        .y_o (not_y)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    issue   = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (y_ready) begin
                    if (|req) begin
                        issue = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic: result registers only load on an issue edge.
    always_comb begin
        gnt_d     = 4'b0000;
        y_d       = y_q;
        y_id_d    = y_id_q;
        y_valid_d = (state_d == HOLD);
        if (issue) begin
            gnt_d  = 4'b0001 << win;
            y_d    = not_y;
            y_id_d = win;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_q     <= 4'b0000;
            y_q       <= 16'h0000;
            y_id_q    <= 2'd0;
            y_valid_q <= 1'b0;
        end else begin
            gnt_q     <= gnt_d;
            y_q       <= y_d;
            y_id_q    <= y_id_d;
            y_valid_q <= y_valid_d;
        end
    end

    assign gnt     = gnt_q;
    assign y       = y_q;
    assign y_id    = y_id_q;
    assign y_valid = y_valid_q;
endmodule

// File: tb/tb_gnot16_arbiter.sv
// Directed bench for gnot16_arbiter: a vector table plus hand-written multi-cycle sequences.
// Round-robin expectations are selected when GNOT16_ARB_RR_EN is defined.

module tb_gnot16_arbiter;
    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [63:0] a_bus;
    logic [3:0]  gnt;
    logic [15:0] y;
    logic [1:0]  y_id;
    logic        y_valid;
    logic        y_ready;

    int n_total;
    int n_pass;

    gnot16_arbiter dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .a_bus   (a_bus),
        .gnt     (gnt),
        .y       (y),
        .y_id    (y_id),
        .y_valid (y_valid),
        .y_ready (y_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [63:0] a;
        logic        rdy;
        logic [3:0]  gnt;
        logic [15:0] y;
        logic [1:0]  id;
        logic        v;
    } vec_t;

    vec_t vecs[11];

    // Drive inputs, take one rising edge, settle 1 time unit past it.
    task automatic step(input logic r, input logic [3:0] rq, input logic [63:0] a, input logic rdy);
        rst     = r;
        req     = rq;
        a_bus   = a;
        y_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [3:0] eg, input logic [15:0] ey,
                         input logic [1:0] eid, input logic ev);
        n_total++;
        if (gnt === eg) n_pass++;
        else $display("FAIL %s gnt got %b want %b", name, gnt, eg);
        n_total++;
        if (y === ey) n_pass++;
        else $display("FAIL %s y got %h want %h", name, y, ey);
        n_total++;
        if (y_id === eid) n_pass++;
        else $display("FAIL %s y_id got %0d want %0d", name, y_id, eid);
        n_total++;
        if (y_valid === ev) n_pass++;
        else $display("FAIL %s y_valid got %b want %b", name, y_valid, ev);
    endtask

    initial begin
        logic [15:0] ya1;
        n_total = 0;
        n_pass  = 0;
        rst = 1'b1; req = 4'b0; a_bus = 64'h0; y_ready = 1'b0;

        //          rst   req      a_bus                    rdy   gnt      y         id    v
        vecs[0]  = '{1'b1, 4'b0000, 64'h0,                   1'b0, 4'b0000, 16'h0000, 2'd0, 1'b0};
        vecs[1]  = '{1'b0, 4'b0100, 64'h0000_00FF_0000_0000, 1'b1, 4'b0100, 16'hFF00, 2'd2, 1'b1};
        vecs[2]  = '{1'b0, 4'b0000, 64'h0,                   1'b1, 4'b0000, 16'hFF00, 2'd2, 1'b0};
        vecs[3]  = '{1'b0, 4'b0000, 64'h0,                   1'b1, 4'b0000, 16'hFF00, 2'd2, 1'b0};
        vecs[4]  = '{1'b0, 4'b0001, 64'h0,                   1'b1, 4'b0001, 16'hFFFF, 2'd0, 1'b1};
        vecs[5]  = '{1'b0, 4'b1000, 64'hFFFF_0000_0000_0000, 1'b1, 4'b1000, 16'h0000, 2'd3, 1'b1};
        vecs[6]  = '{1'b0, 4'b0000, 64'h0,                   1'b0, 4'b0000, 16'h0000, 2'd3, 1'b1};
        vecs[7]  = '{1'b0, 4'b0000, 64'h0,                   1'b1, 4'b0000, 16'h0000, 2'd3, 1'b0};
        vecs[8]  = '{1'b0, 4'b0011, 64'h0000_0000_2222_1111, 1'b1, 4'b0001, 16'hEEEE, 2'd0, 1'b1};
        vecs[9]  = '{1'b0, 4'b0010, 64'h0000_0000_2222_1111, 1'b1, 4'b0010, 16'hDDDD, 2'd1, 1'b1};
        vecs[10] = '{1'b0, 4'b0000, 64'h0,                   1'b1, 4'b0000, 16'hDDDD, 2'd1, 1'b0};

        for (int i = 0; i < 11; i++) begin
            step(vecs[i].rst, vecs[i].req, vecs[i].a, vecs[i].rdy);
            check($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].y, vecs[i].id, vecs[i].v);
        end

        // Backpressure: result held while a0 wiggles and requester 1 waits.
        step(1'b0, 4'b0001, 64'h0000_0000_0000_1234, 1'b0);
        check("bp_issue", 4'b0001, 16'hEDCB, 2'd0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 4'b0010, {48'h0000_0000_0F0F, 16'($urandom_range(0, 65535))}, 1'b0);
            check($sformatf("bp_hold%0d", i), 4'b0000, 16'hEDCB, 2'd0, 1'b1);
        end
        step(1'b0, 4'b0010, 64'h0000_0000_0F0F_0000, 1'b1);
        check("bp_b2b", 4'b0010, 16'hF0F0, 2'd1, 1'b1);
        step(1'b0, 4'b0000, 64'h0, 1'b1);
        check("bp_drain", 4'b0000, 16'hF0F0, 2'd1, 1'b0);

        // Reset in the middle of HOLD discards the result and blocks the grant on that edge.
        step(1'b0, 4'b0001, 64'h0000_0000_0000_AAAA, 1'b0);
        check("rst_issue", 4'b0001, 16'h5555, 2'd0, 1'b1);
        step(1'b1, 4'b0001, 64'h0000_0000_0000_AAAA, 1'b1);
        check("rst_edge", 4'b0000, 16'h0000, 2'd0, 1'b0);
        step(1'b0, 4'b0001, 64'h0000_0000_0000_AAAA, 1'b0);
        check("rst_regrant", 4'b0001, 16'h5555, 2'd0, 1'b1);
        step(1'b0, 4'b0000, 64'h0, 1'b1);
        check("rst_drain", 4'b0000, 16'h5555, 2'd0, 1'b0);

        // Contention
        step(1'b1, 4'b0000, 64'h0, 1'b0);
        check("ct_reset", 4'b0000, 16'h0000, 2'd0, 1'b0);
`ifdef GNOT16_ARB_RR_EN
        for (int i = 0; i < 5; i++) begin
            logic [1:0]  w;
            logic [15:0] ey;
            w  = 2'(i % 4);
            ey = ~(16'h0001 << w);
            step(1'b0, 4'b1111, 64'h0008_0004_0002_0001, 1'b1);
            check($sformatf("rr%0d", i), 4'b0001 << w, ey, w, 1'b1);
        end
`else
        ya1 = 16'h3C5A;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 4'b1010, {16'h9999, 16'h0, ya1, 16'h0}, 1'b1);
            check($sformatf("fp%0d", i), 4'b0010, ~ya1, 2'd1, 1'b1);
        end
        step(1'b0, 4'b1000, 64'h9999_0000_0000_0000, 1'b1);
        check("fp_req3", 4'b1000, 16'h6666, 2'd3, 1'b1);
`endif
        step(1'b0, 4'b0000, 64'h0, 1'b1);
        check("ct_drain", 4'b0000, y, y_id, 1'b0);

        // Quiet bus: no request means no grant and no valid, whatever y_ready does.
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 4'b0000, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
            n_total++;
            if (gnt === 4'b0000 && y_valid === 1'b0) n_pass++;
            else $display("FAIL idle%0d gnt/y_valid got %b/%b want 0000/0", i, gnt, y_valid);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
